// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage
// and the IF/ID register that follows it.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'hE000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the pc, fetches over req/ack, and presents
// an instruction or a NOP bubble to the IF register every cycle.
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        if_valid
);

    if_state_e   state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] hold_buf;
    logic [31:0] drop_addr;

    assign pc_next = pc + PC_STEP;

    // DROP keeps driving the address of the fetch that cannot be aborted
    always_comb begin
        imem_req    = (state != HOLD);
        imem_addr   = (state == DROP) ? drop_addr : pc;
        PC          = 32'h0;
        Instruction = NOP_INSTRUCTION;
        if_valid    = 1'b0;
        unique case (state)
            FETCH: begin
                if (imem_ack && !branch_taken) begin
                    PC          = pc_next;
                    Instruction = imem_rdata;
                    if_valid    = 1'b1;
                end
            end
            HOLD: begin
                if (!branch_taken) begin
                    PC          = pc_next;
                    Instruction = hold_buf;
                    if_valid    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC & PC_ALIGN_MASK;
            hold_buf  <= NOP_INSTRUCTION;
            drop_addr <= RESET_PC & PC_ALIGN_MASK;
        end else if (branch_taken) begin
            pc <= branch_address & PC_ALIGN_MASK;
            unique case (state)
                FETCH: begin
                    if (!imem_ack) begin
                        state     <= DROP;
                        drop_addr <= pc;
                    end
                end
                HOLD: state <= FETCH;
                DROP: begin
                    if (imem_ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (freeze) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            pc <= pc_next;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
